// File: rtl/ntt_bfu_permute.sv
// ML-KEM (q = 3329) NTT datapath: 4-stage CT/GS butterfly with Montgomery/Barrett
// reduction, and the lane shuffle network placed after the butterfly array.
`default_nettype none

module BFU (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_intt,
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    input  logic signed [15:0] i_twiddle,
    output logic signed [15:0] o_a,
    output logic signed [15:0] o_b
);
    localparam logic signed [31:0] c_q       = 32'sd3329;
    localparam logic        [15:0] c_qinv    = 16'hF301;
    localparam logic signed [31:0] c_bar_v   = 32'sd20159;
    localparam logic signed [31:0] c_bar_rnd = 32'sd33554432;

    logic               s1_intt_q;
    logic signed [15:0] s1_a_q, s1_b_q, s1_z_q;
    logic               s2_intt_q;
    logic signed [15:0] s2_a_q, s2_sum_q;
    logic signed [31:0] s2_prod_q, s2_bprod_q;
    logic               s3_intt_q;
    logic signed [15:0] s3_a_q, s3_mont_q, s3_barr_q;
    logic signed [15:0] s4_a_q, s4_b_q;

    // Stage 2: pre-add/sub, Montgomery product and Barrett estimate product
    logic signed [15:0] w_sum, w_dif, w_mop;
    logic signed [31:0] s2_prod_d, s2_bprod_d;
    assign w_sum      = s1_a_q + s1_b_q;
    assign w_dif      = s1_b_q - s1_a_q;
    assign w_mop      = s1_intt_q ? w_dif : s1_b_q;
    assign s2_prod_d  = $signed({{16{s1_z_q[15]}}, s1_z_q}) * $signed({{16{w_mop[15]}}, w_mop});
    assign s2_bprod_d = $signed({{16{w_sum[15]}}, w_sum}) * c_bar_v + c_bar_rnd;

    // Stage 3: Montgomery fold of the product, Barrett subtraction of the sum
    logic        [15:0] w_t;
    logic signed [31:0] w_tq, w_mdiff, w_bq, w_bt, w_sum32;
    logic signed [15:0] s3_mont_d, s3_barr_d;
    assign w_t       = s2_prod_q[15:0] * c_qinv;
    assign w_tq      = $signed({{16{w_t[15]}}, w_t}) * c_q;
    assign w_mdiff   = s2_prod_q - w_tq;
    assign s3_mont_d = 16'(w_mdiff >>> 16);
    assign w_bq      = s2_bprod_q >>> 26;
    assign w_bt      = w_bq * c_q;
    assign w_sum32   = $signed({{16{s2_sum_q[15]}}, s2_sum_q});
    assign s3_barr_d = 16'(w_sum32 - w_bt);

    logic signed [15:0] s4_a_d, s4_b_d;
    assign s4_a_d = s3_intt_q ? s3_barr_q : s3_a_q + s3_mont_q;
    assign s4_b_d = s3_intt_q ? s3_mont_q : s3_a_q - s3_mont_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_intt_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_z_q     <= '0;
            s2_intt_q  <= 1'b0;
            s2_a_q     <= '0;
            s2_sum_q   <= '0;
            s2_prod_q  <= '0;
            s2_bprod_q <= '0;
            s3_intt_q  <= 1'b0;
            s3_a_q     <= '0;
            s3_mont_q  <= '0;
            s3_barr_q  <= '0;
            s4_a_q     <= '0;
            s4_b_q     <= '0;
        end else begin
            s1_intt_q  <= i_intt;
            s1_a_q     <= i_a;
            s1_b_q     <= i_b;
            s1_z_q     <= i_twiddle;
            s2_intt_q  <= s1_intt_q;
            s2_a_q     <= s1_a_q;
            s2_sum_q   <= w_sum;
            s2_prod_q  <= s2_prod_d;
            s2_bprod_q <= s2_bprod_d;
            s3_intt_q  <= s2_intt_q;
            s3_a_q     <= s2_a_q;
            s3_mont_q  <= s3_mont_d;
            s3_barr_q  <= s3_barr_d;
            s4_a_q     <= s4_a_d;
            s4_b_q     <= s4_b_d;
        end
    end

    assign o_a = s4_a_q;
    assign o_b = s4_b_q;
endmodule

module PERMUTE_NTT #(
    parameter int HALF_NUM_BFU = 16
) (
    input  logic [2*HALF_NUM_BFU-1:0][15:0] i_a,
    input  logic [2*HALF_NUM_BFU-1:0][15:0] i_b,
    output logic [2*HALF_NUM_BFU-1:0][15:0] o_a,
    output logic [2*HALF_NUM_BFU-1:0][15:0] o_b
);
    for (genvar k = 0; k < HALF_NUM_BFU; k++) begin : g_lane
        assign o_a[2*k]   = i_a[k];
        assign o_a[2*k+1] = i_b[k];
        assign o_b[2*k]   = i_a[k+HALF_NUM_BFU];
        assign o_b[2*k+1] = i_b[k+HALF_NUM_BFU];
    end
endmodule

module ntt_bfu_permute #(
    parameter int HALF_NUM_BFU = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_intt,
    input  logic signed [15:0]              i_a,
    input  logic signed [15:0]              i_b,
    input  logic signed [15:0]              i_twiddle,
    output logic signed [15:0]              o_a,
    output logic signed [15:0]              o_b,
    input  logic [2*HALF_NUM_BFU-1:0][15:0] i_perm_a,
    input  logic [2*HALF_NUM_BFU-1:0][15:0] i_perm_b,
    output logic [2*HALF_NUM_BFU-1:0][15:0] o_perm_a,
    output logic [2*HALF_NUM_BFU-1:0][15:0] o_perm_b,
    output logic [2*HALF_NUM_BFU-1:0][15:0] o_perm2_a,
    output logic [2*HALF_NUM_BFU-1:0][15:0] o_perm2_b
);
    BFU u_bfu (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_intt    (i_intt),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_twiddle (i_twiddle),
        .o_a       (o_a),
        .o_b       (o_b)
    );

    // Second instance is the double shuffle used by the last NTT stage
    PERMUTE_NTT #(.HALF_NUM_BFU(HALF_NUM_BFU)) u_perm0 (
        .i_a (i_perm_a),
        .i_b (i_perm_b),
        .o_a (o_perm_a),
        .o_b (o_perm_b)
    );

    PERMUTE_NTT #(.HALF_NUM_BFU(HALF_NUM_BFU)) u_perm1 (
        .i_a (o_perm_a),
        .i_b (o_perm_b),
        .o_a (o_perm2_a),
        .o_b (o_perm2_b)
    );
endmodule

`default_nettype wire

// File: tb/tb_ntt_bfu_permute.sv
// Bench for ntt_bfu_permute: butterfly vs. arithmetic reference with a latency
// queue, plus lane-shuffle mapping checks.
`default_nettype none

module tb_ntt_bfu_permute;
    localparam int H = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic intt = 1'b0;
    logic signed [15:0] a_in = '0, b_in = '0, z_in = '0;
    logic signed [15:0] a_out, b_out;
    logic [2*H-1:0][15:0] pa, pb, poa, pob, p2a, p2b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } res_t;
    res_t exp_q[$];

    ntt_bfu_permute #(.HALF_NUM_BFU(H)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_intt    (intt),
        .i_a       (a_in),
        .i_b       (b_in),
        .i_twiddle (z_in),
        .o_a       (a_out),
        .o_b       (b_out),
        .i_perm_a  (pa),
        .i_perm_b  (pb),
        .o_perm_a  (poa),
        .o_perm_b  (pob),
        .o_perm2_a (p2a),
        .o_perm2_b (p2b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic shortint fqmul(input shortint x, input shortint y);
        longint p, r;
        shortint t;
        p = longint'(x) * longint'(y);
        t = shortint'(p * -3327);
        r = (p - longint'(t) * 3329) >>> 16;
        return shortint'(r);
    endfunction

    function automatic shortint barrett(input shortint x);
        longint xl, t;
        xl = longint'(x);
        t  = ((20159 * xl + 33554432) >>> 26) * 3329;
        return shortint'(xl - t);
    endfunction

    function automatic res_t bfu_model(input bit m, input shortint a, input shortint b, input shortint z);
        res_t r;
        shortint t, s, d;
        if (!m) begin
            t   = fqmul(z, b);
            r.a = 16'(int'(a) + int'(t));
            r.b = 16'(int'(a) - int'(t));
        end else begin
            s   = shortint'(int'(a) + int'(b));
            d   = shortint'(int'(b) - int'(a));
            r.a = barrett(s);
            r.b = fqmul(z, d);
        end
        return r;
    endfunction

    function automatic void shuffle(input logic [2*H-1:0][15:0] ia, input logic [2*H-1:0][15:0] ib,
                                    output logic [2*H-1:0][15:0] oa, output logic [2*H-1:0][15:0] ob);
        for (int k = 0; k < H; k++) begin
            oa[2*k]   = ia[k];
            oa[2*k+1] = ib[k];
            ob[2*k]   = ia[k+H];
            ob[2*k+1] = ib[k+H];
        end
    endfunction

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back('0);
    endtask

    // Apply one input, clock once, and compare against the result captured four edges back
    task automatic cyc(input bit m, input shortint a, input shortint b, input shortint z);
        res_t e;
        intt = m;
        a_in = a;
        b_in = b;
        z_in = z;
        @(posedge clk);
        exp_q.push_back(bfu_model(m, a, b, z));
        void'(exp_q.pop_front());
        #1;
        e = exp_q[0];
        check("bfu_a", int'(a_out), int'($signed(e.a)));
        check("bfu_b", int'(b_out), int'($signed(e.b)));
    endtask

    task automatic hold4(input bit m, input shortint a, input shortint b, input shortint z);
        for (int i = 0; i < 4; i++) cyc(m, a, b, z);
    endtask

    initial begin
        logic [2*H-1:0][15:0] ea, eb, ea2, eb2;

        clear_model();
        pa = '0;
        pb = '0;
        #1;
        check("rst_a", int'(a_out), 0);
        check("rst_b", int'(b_out), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        hold4(1'b0, 16'sd100, 16'sd200, -16'sd1044);
        check("fwd_id_a", int'(a_out), 300);
        check("fwd_id_b", int'(b_out), -100);

        hold4(1'b1, 16'sd100, 16'sd200, -16'sd1044);
        check("inv_id_a", int'(a_out), 300);
        check("inv_id_b", int'(b_out), 100);

        hold4(1'b1, 16'sd3000, 16'sd3000, 16'sd0);
        check("barrett_a", int'(a_out), -658);
        check("barrett_b", int'(b_out), 0);

        hold4(1'b0, 16'sd5, 16'sd9, 16'sd0);
        check("fwd_z0_a", int'(a_out), 5);
        check("fwd_z0_b", int'(b_out), 5);

        // Mode toggling back-to-back stream, then an asynchronous reset mid-stream
        for (int i = 0; i < 6; i++)
            cyc(1'(i % 2), shortint'($urandom), shortint'($urandom), shortint'($urandom));
        #3;
        rst = 1'b1;
        #1;
        check("midrst_a", int'(a_out), 0);
        check("midrst_b", int'(b_out), 0);
        clear_model();
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold_a", int'(a_out), 0);
            check("rst_hold_b", int'(b_out), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++)
            cyc(1'(i % 2), shortint'($urandom), shortint'($urandom), shortint'($urandom));

        for (int i = 0; i < 10000; i++)
            cyc(1'($urandom_range(0, 1)), shortint'($urandom), shortint'($urandom), shortint'($urandom));

        for (int k = 0; k < 2*H; k++) begin
            pa[k] = 16'(k);
            pb[k] = 16'(32 + k);
        end
        #1;
        for (int k = 0; k < H; k++) begin
            check("perm_a_even", int'(poa[2*k]),   k);
            check("perm_a_odd",  int'(poa[2*k+1]), 32 + k);
            check("perm_b_even", int'(pob[2*k]),   16 + k);
            check("perm_b_odd",  int'(pob[2*k+1]), 48 + k);
        end
        shuffle(pa, pb, ea, eb);
        shuffle(ea, eb, ea2, eb2);
        for (int k = 0; k < 2*H; k++) begin
            check("perm2_a", int'(p2a[k]), int'(ea2[k]));
            check("perm2_b", int'(p2b[k]), int'(eb2[k]));
        end

        repeat (20) begin
            for (int k = 0; k < 2*H; k++) begin
                pa[k] = 16'($urandom);
                pb[k] = 16'($urandom);
            end
            #1;
            shuffle(pa, pb, ea, eb);
            shuffle(ea, eb, ea2, eb2);
            for (int k = 0; k < 2*H; k++) begin
                check("perm_rand_a",  int'(poa[k]), int'(ea[k]));
                check("perm_rand_b",  int'(pob[k]), int'(eb[k]));
                check("perm2_rand_a", int'(p2a[k]), int'(ea2[k]));
                check("perm2_rand_b", int'(p2b[k]), int'(eb2[k]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
